// File: rtl/sram_pkg.sv
// Shared types and helpers for the lane-addressed SRAM model.
// Word and mask types are sized for the widest supported bus; instances truncate.
package sram_pkg;

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned MAX_LANES    = 8;
    localparam int unsigned MAX_READ_LAT = 4;

    typedef logic [MAX_LANES-1:0]        lane_mask_t;
    typedef logic [BYTE_W*MAX_LANES-1:0] word_t;

    // Replace every lane whose active-low enable is asserted; keep the rest.
    function automatic word_t lane_merge(input word_t old_word, input word_t new_word,
                                         input lane_mask_t be_n);
        word_t merged;
        merged = old_word;
        for (int k = 0; k < int'(MAX_LANES); k++) begin
            if (!be_n[k]) begin
                merged[BYTE_W*k +: BYTE_W] = new_word[BYTE_W*k +: BYTE_W];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line: LAT stages of {valid, lane mask, data}, cleared asynchronously.
// LAT = 0 passes the sample straight through for a combinational read.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int unsigned LAT   = 1,
    parameter int unsigned LANES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [LANES-1:0]        in_mask,
    input  logic [BYTE_W*LANES-1:0] in_data,
    output logic                    out_valid,
    output logic [LANES-1:0]        out_mask,
    output logic [BYTE_W*LANES-1:0] out_data
);

    generate
        if (LAT == 0) begin : g_bypass
            logic unused_clk;
            assign unused_clk = clk;
            assign out_valid  = in_valid & ~rst;
            assign out_mask   = in_mask;
            assign out_data   = in_data;
        end else begin : g_pipe
            logic                    valid_q [LAT];
            logic [LANES-1:0]        mask_q  [LAT];
            logic [BYTE_W*LANES-1:0] data_q  [LAT];

            // Shift every cycle; idle cycles push bubbles.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(LAT); i++) begin
                        valid_q[i] <= 1'b0;
                        mask_q[i]  <= '0;
                        data_q[i]  <= '0;
                    end
                end else begin
                    valid_q[0] <= in_valid;
                    mask_q[0]  <= in_mask;
                    data_q[0]  <= in_data;
                    for (int i = 1; i < int'(LAT); i++) begin
                        valid_q[i] <= valid_q[i-1];
                        mask_q[i]  <= mask_q[i-1];
                        data_q[i]  <= data_q[i-1];
                    end
                end
            end

            assign out_valid = valid_q[LAT-1];
            assign out_mask  = mask_q[LAT-1];
            assign out_data  = data_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/sram_lane_model.sv
// Clocked async-SRAM model with active-low controls, N byte lanes, configurable
// read latency, contention flag and saturating access counters.
module sram_lane_model
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned LANES    = 2,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned COUNT_W  = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [ADDR_W-1:0]        A,
    inout  logic [BYTE_W*LANES-1:0]  I_O,
    input  logic                     CE,
    input  logic                     OE,
    input  logic                     WE,
    input  logic [LANES-1:0]         BE,
    output logic                     rd_valid,
    output logic                     err_contention,
    output logic [COUNT_W-1:0]       rd_count,
    output logic [COUNT_W-1:0]       wr_count
);

    localparam int unsigned DATA_W = BYTE_W * LANES;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LAT    = (READ_LAT > MAX_READ_LAT) ? MAX_READ_LAT : READ_LAT;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              unused_addr;
    logic              rd_cycle;
    logic              wr_cycle;
    logic              conflict;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_word;
    logic              pipe_valid;
    logic [LANES-1:0]  pipe_mask;
    logic [DATA_W-1:0] pipe_data;
    logic [LANES-1:0]  drive;

    // Upper address bits alias onto the implemented depth.
    assign idx         = IDX_W'(A);
    assign unused_addr = ^A;

    always_comb begin
        rd_cycle = 1'b0;
        wr_cycle = 1'b0;
        conflict = 1'b0;
        if (!CE) begin
            rd_cycle = !OE && WE;
            wr_cycle = !WE;
            conflict = !OE && !WE;
        end
    end

    assign rd_word = mem[idx];
    assign wr_word = DATA_W'(lane_merge(word_t'(rd_word), word_t'(I_O), lane_mask_t'(BE)));

    // Array has no reset; an edge seen while Reset is high never writes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (!Reset && wr_cycle) begin
            mem[idx] <= wr_word;
        end
    end

    sram_rd_pipe #(
        .LAT   (LAT),
        .LANES (LANES)
    ) u_rd_pipe (
        .clk       (Clk),
        .rst       (Reset),
        .in_valid  (rd_cycle),
        .in_mask   (~BE),
        .in_data   (rd_word),
        .out_valid (pipe_valid),
        .out_mask  (pipe_mask),
        .out_data  (pipe_data)
    );

    // Drive only when the exiting entry is valid and the bus is in a read cycle now.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign drive[k] = pipe_valid & pipe_mask[k] & rd_cycle & ~Reset;
        assign I_O[BYTE_W*k +: BYTE_W] = drive[k] ? pipe_data[BYTE_W*k +: BYTE_W]
                                                  : {BYTE_W{1'bz}};
    end

    assign rd_valid = |drive;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_count       <= '0;
            wr_count       <= '0;
            err_contention <= 1'b0;
        end else begin
            if (rd_cycle && (rd_count != '1)) begin
                rd_count <= rd_count + COUNT_W'(1);
            end
            if (wr_cycle && (wr_count != '1)) begin
                wr_count <= wr_count + COUNT_W'(1);
            end
            if (conflict) begin
                err_contention <= 1'b1;
            end
        end
    end

endmodule
